// File: rtl/lut_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lut_sweep_ctrl
// Purpose  : Sweeps every code in [lo, hi] through an external combinational
//            code mapper. Each code is held for SETTLE+1 cycles and sampled
//            on the last one. The sweep reports how many codes map to the
//            target, and the lowest such code.
// Ports    : clk, rst          - clock, async active-high reset
//            start             - sweep request (sampled in IDLE only)
//            lo, hi, target    - sweep bounds and compare value (captured)
//            lut_in / lut_out  - drive to / response from the mapper
//            busy, done, err   - sweep active, end pulse, lo>hi rejection
//            match_cnt, hit_valid, first_hit - sweep results
// Revision : 1.0 - initial release
// ============================================================================
module lut_sweep_ctrl #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] target,
  output logic [W-1:0] lut_in,
  input  logic [W-1:0] lut_out,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W:0]   match_cnt,
  output logic         hit_valid,
  output logic [W-1:0] first_hit
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [3:0] c_settle = 4'(SETTLE);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_settle;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_target;
  logic [W-1:0] r_lut_in;
  logic [W:0]   r_match_cnt;
  logic         r_hit_valid;
  logic [W-1:0] r_first_hit;
  logic         r_err;

  logic w_accept;
  logic w_reject;
  logic w_sample;
  logic w_hit;
  logic w_last;

  // --------------------------------------------------------------------------
  // Next-state and status decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = (r_state == ST_IDLE) && start && (lo <= hi);
    w_reject    = (r_state == ST_IDLE) && start && (lo > hi);
    w_sample    = (r_state == ST_SCAN) && (r_settle == c_settle);
    w_hit       = w_sample && (lut_out == r_target);
    // End test uses the code currently driven, so hi = all-ones stops
    // before lut_in could wrap back to zero.
    w_last      = w_sample && (r_lut_in == r_hi);
    busy        = (r_state == ST_SCAN);
    done        = (r_state == ST_FIN);

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SCAN;
        end else if (w_reject) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_SCAN: begin
        if (w_last) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Sweep datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle    <= '0;
      r_hi        <= '0;
      r_target    <= '0;
      r_lut_in    <= '0;
      r_match_cnt <= '0;
      r_hit_valid <= 1'b0;
      r_first_hit <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_hi        <= hi;
      r_target    <= target;
      r_lut_in    <= lo;
      r_settle    <= '0;
      r_match_cnt <= '0;
      r_hit_valid <= 1'b0;
      r_first_hit <= '0;
      r_err       <= 1'b0;
    end else if (w_reject) begin
      // No code is driven: lut_in keeps its previous value.
      r_match_cnt <= '0;
      r_hit_valid <= 1'b0;
      r_first_hit <= '0;
      r_err       <= 1'b1;
    end else if (r_state == ST_SCAN) begin
      if (!w_sample) begin
        r_settle <= r_settle + 4'd1;
      end else begin
        if (w_hit) begin
          r_match_cnt <= r_match_cnt + (W+1)'(1);
          // Codes ascend, so the first hit seen is the lowest one.
          if (!r_hit_valid) begin
            r_first_hit <= r_lut_in;
            r_hit_valid <= 1'b1;
          end
        end
        if (!w_last) begin
          r_lut_in <= r_lut_in + W'(1);
          r_settle <= '0;
        end
      end
    end
  end

  assign lut_in    = r_lut_in;
  assign match_cnt = r_match_cnt;
  assign hit_valid = r_hit_valid;
  assign first_hit = r_first_hit;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/lut_sweep_ctrl.md
Name: lut_sweep_ctrl

Overview:
- Sequencer for the team's 4-bit combinational code-mapping block (4-bit code in, 4-bit code out).
- On a start request it drives every code in [lo, hi] into the mapper, one code at a time.
- After a settle window it samples the mapper output and compares it against a target.
- Reports the match count and the first matching code. Used for self-test and for reverse lookup of the mapping table.

Parameters:
- W, 4: code width. Mapper input and output are both W bits.
- SETTLE, 1: extra cycles each code is held before sampling. Each code occupies SETTLE+1 cycles. Legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a sweep; sampled only in IDLE
- lo  input  W  first code of the sweep; captured when start is accepted
- hi  input  W  last code of the sweep, inclusive; captured when start is accepted
- target  input  W  value compared against mapper output; captured when start is accepted
- lut_in  output  W  code driven to the mapper input
- lut_out  input  W  mapper output (combinational response to lut_in)
- busy  output  1  high while a sweep is in progress
- done  output  1  single-cycle pulse when a sweep or a rejected request completes
- err  output  1  high when the last request had lo > hi; held until the next accepted start
- match_cnt  output  W+1  number of codes in [lo, hi] whose mapped value equals target
- hit_valid  output  1  at least one match found in the last sweep
- first_hit  output  W  lowest matching code; 0 when hit_valid=0

Behaviour:
- Reset (async, any state): state=IDLE. lut_in, busy, done, err, match_cnt, hit_valid, first_hit all 0. Settle counter 0.
- FSM states: IDLE, SCAN, FIN.
- IDLE:
  - start=1 and lo<=hi: capture lo/hi/target; clear match_cnt, hit_valid, first_hit, err; lut_in<=lo; settle counter<=0; busy<=1; go to SCAN.
  - start=1 and lo>hi: clear the results; err<=1; go to FIN. No code is driven and lut_in is unchanged.
- SCAN: each cycle, if the settle counter is below SETTLE, increment it. Otherwise it is the sample cycle:
  - If lut_out==target: match_cnt+=1. If hit_valid=0, set first_hit<=lut_in and hit_valid<=1.
  - If lut_in==hi: busy<=0 and go to FIN.
  - Otherwise lut_in<=lut_in+1 and the settle counter<=0.
- End detection compares lut_in==hi before incrementing. hi=2^W-1 must terminate without wrapping lut_in to 0. match_cnt is W+1 bits so a full 16-code sweep can report 16.
- FIN: done=1 for exactly one cycle, then go to IDLE. busy is 0 in FIN.
- Results (match_cnt, hit_valid, first_hit, err) and the last lut_in hold in IDLE until the next accepted start.
- Timing: start accepted at edge E. busy is high for (hi-lo+1)*(SETTLE+1) cycles starting after E. done is high in the following cycle. Rejected request: done is high in the cycle after E.
- start while busy or in FIN is ignored. It is not queued.
- lo, hi and target changing during a sweep have no effect, because they were captured at start.
- Reset mid-sweep aborts immediately: no done pulse, all outputs return to their reset values.

Test Plan:
- SETTLE=1, lo=0, hi=15, target=4'b0011 -> busy for 32 cycles, one done pulse, match_cnt=10, hit_valid=1, first_hit=0, err=0.
- lo=0, hi=15, target=4'b1101 -> match_cnt=1, first_hit=4'b1000. Then target=4'b0000 -> match_cnt=0, hit_valid=0, first_hit=0.
- lo=9, hi=9, target=4'b1100, SETTLE=1 -> busy for exactly 2 cycles, match_cnt=1, first_hit=9. Repeat with lo=hi=15, target=4'b1001 -> match_cnt=1 and lut_in ends at 15 without wrapping.
- lo=5, hi=2 -> err=1, done high in the cycle after the start edge, busy never high, match_cnt=0. A following valid start clears err.
- Assert start again 3 cycles into a 0..15 sweep -> ignored, and the sweep completes with the same results as in the first scenario.
- Assert rst asynchronously (mid-cycle) at sweep cycle 10 -> all outputs 0 immediately, no done pulse. A new start after release runs a normal sweep.
